// File: rtl/zone_stream_tx.sv
// zone_stream_tx: snapshots the 360-zone buffer on frame_start and
// shifts it to the MiniLED chain serpentine, MSB first, then latches.
module zone_stream_tx #(
  parameter int ZONES   = 360,
  parameter int COLS    = 24,
  parameter int ROWS    = 15,
  parameter int CLK_DIV = 4
) (
  input  logic               clk_x1,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [ZONES*8-1:0] buf_360_flatted,
  output logic               busy,
  output logic               led_sclk,
  output logic               led_sdat,
  output logic               led_lat,
  output logic               frame_done
);

  localparam int ZW = $clog2(ZONES);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = $clog2(ZONES*8);
  localparam int DW = $clog2(2*CLK_DIV+1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DONE
  } state_t;

  state_t             state_q;
  logic [ZONES*8-1:0] snap_q;
  logic [ZW-1:0]      zone_q, zone_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [2:0]         bit_q, bit_d;
  logic [DW-1:0]      div_q;
  logic [IW-1:0]      idx_d;
  logic               busy_q, sclk_q, sdat_q;
  logic               lat_q, done_q;
  logic               last_bit, div_end, lat_end;

  // Next (zone, bit) in serpentine order and its snapshot position
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    zone_d = zone_q;
    bit_d  = bit_q - 3'd1;
    if (bit_q == 3'd0) begin
      bit_d  = 3'd7;
      zone_d = zone_q + ZW'(1);
      if (!row_q[0]) begin
        if (col_q == CW'(COLS-1)) row_d = row_q + RW'(1);
        else col_d = col_q + CW'(1);
      end else begin
        if (col_q == '0) row_d = row_q + RW'(1);
        else col_d = col_q - CW'(1);
      end
    end
    idx_d = IW'((int'(row_d) * COLS + int'(col_d)) * 8
                + int'(bit_d));
  end

  assign last_bit = (zone_q == ZW'(ZONES-1)) && (bit_q == 3'd0);
  assign div_end  = (div_q == DW'(CLK_DIV-1));
  assign lat_end  = (div_q == DW'(2*CLK_DIV-1));

  always_ff @(posedge clk_x1) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      lat_q   <= 1'b0;
      done_q  <= 1'b0;
      zone_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            snap_q  <= buf_360_flatted;
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdat_q  <= buf_360_flatted[7];
            zone_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            bit_q   <= 3'd7;
            div_q   <= '0;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_q <= div_q + DW'(1);
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (last_bit) begin
                state_q <= LATCH;
                sdat_q  <= 1'b0;
                lat_q   <= 1'b1;
              end else begin
                zone_q <= zone_d;
                row_q  <= row_d;
                col_q  <= col_d;
                bit_q  <= bit_d;
                sdat_q <= snap_q[idx_d];
              end
            end
          end
        end
        LATCH: begin
          if (!lat_end) begin
            div_q <= div_q + DW'(1);
          end else begin
            div_q   <= '0;
            state_q <= DONE;
            lat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign led_sclk   = sclk_q;
  assign led_sdat   = sdat_q;
  assign led_lat    = lat_q;
  assign frame_done = done_q;

endmodule

// File: doc/zone_stream_tx.md
# zone_stream_tx

Serializes the 360 backlight zone gray levels held in the zone buffer's flattened output bus to the MiniLED driver chain. On a frame start it snapshots all zones, streams them over a clock/data/latch serial link in the panel's serpentine wiring order, MSB first, then pulses latch. It sits between the zone buffer (written by the per-zone averaging path) and the LED driver pins.

## Interface
- ZONES, 360, number of zones; must equal ROWS*COLS
- COLS, 24, zones per panel row
- ROWS, 15, panel rows
- CLK_DIV, 4, clk_x1 cycles per half period of led_sclk (≥1)
- clk_x1  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- frame_start  in  1  one-cycle request to send a frame; honoured only in IDLE
- buf_360_flatted  in  ZONES*8  zone z (0-based, z = row*COLS + col) at bits [z*8 +: 8]
- busy  out  1  high from acceptance of frame_start until frame_done
- led_sclk  out  1  serial clock to driver; driver samples led_sdat on rising edge
- led_sdat  out  1  serial data, MSB of each zone first
- led_lat  out  1  latch strobe, high for 2*CLK_DIV cycles after last bit
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE: frame_start=1 -> copy full buf_360_flatted into internal snapshot register, reset zone/bit/divider counters, go SHIFT. Later changes on the input bus do not affect the frame in flight.
- frame_start while not IDLE: ignored, no queuing.
- Send order (serpentine): row r = 0..ROWS-1; even r: col 0..COLS-1; odd r: col COLS-1..0. Within a zone: bit 7 down to bit 0.
- SHIFT: each bit occupies 2*CLK_DIV cycles: led_sclk low for the first CLK_DIV cycles, high for the next CLK_DIV. led_sdat changes only on the cycle led_sclk goes low (or on entry), stable while high.
- After 8*ZONES bits (2880 by default) -> LATCH with led_sclk low, led_sdat 0.
- LATCH: led_lat=1 for exactly 2*CLK_DIV cycles -> DONE.
- DONE: one cycle: frame_done=1, busy=0 in that cycle, led_lat=0 -> IDLE. frame_start in the DONE cycle is ignored.
- Counters: zone counter 0..ZONES-1 (9 bits), bit counter 0..7, divider 0..CLK_DIV-1; column index up/down per row parity, no wrap past row ROWS-1.

## Timing
- Reset values (all outputs): busy 0, led_sclk 0, led_sdat 0, led_lat 0, frame_done 0; state IDLE; snapshot contents irrelevant.
- frame_start high at edge N -> from N+1: busy=1, led_sdat = bit 7 of first zone, led_sclk=0.
- First led_sclk rise at N+1+CLK_DIV; bit k (0-based over frame) led_sclk high during cycles N+1+(2k+1)*CLK_DIV … N+(2k+2)*CLK_DIV.
- Shift phase length 16*ZONES*CLK_DIV cycles (23040 by default); led_lat high cycles N+1+23040 … N+23048; frame_done at N+23049; busy falls same cycle; frame_start accepted again from N+23050.
- rst_n low mid-frame: next edge all outputs to reset values, state IDLE, no latch pulse, no frame_done.
- frame_start and rst_n low in same cycle: reset wins.

## Test plan
- Reset: rst_n low 3 cycles with frame_start toggling -> all outputs 0, busy stays 0.
- Ramp frame: zone z = z mod 256, CLK_DIV=4 -> captured 2880 bits decode to zone order 0..23, 47..24, 48..71, …; first byte 0x00, 25th byte 0x2F (zone 47); led_lat high 8 cycles; frame_done at N+23049.
- Snapshot: start frame with all zones 0xA5, change bus to 0x00 one cycle later -> every received byte 0xA5.
- Ignored start: frame_start pulses mid-SHIFT and in DONE cycle -> exactly one frame sent, one frame_done, busy low after.
- Reset mid-frame after 100 bits -> outputs 0 next edge, no led_lat; subsequent frame_start sends a complete correct frame.
- CLK_DIV=1: zone 0 = 0x80, rest 0 -> led_sclk toggles every cycle, led_sdat high only for first bit, total frame_done at N+1+5760+2.
